// File: rtl/clic_int_src_cond.sv
`default_nettype none
// ============================================================================
// Module   : clic_int_src_cond
// Brief    : Per-line interrupt source conditioner in front of the CLIC kid
//            array. Each raw pin is synchronized, decoded according to its
//            trigger mode (level-high, level-low, rising edge, falling edge)
//            and, for edge modes, held in a pending latch that is cleared by
//            the CLIC acknowledge. The registered result drives
//            pad_clic_int_vld of the kid array directly.
// Revision : 1.0 - initial release
// ============================================================================
module clic_int_src_cond #(
    parameter int INTNUM      = 64,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = 6
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic [INTNUM-1:0]     pad_int_raw,
    input  logic [2*INTNUM-1:0]   cfg_trig_mode,
    input  logic                  clic_int_ack_vld,
    input  logic [ID_W-1:0]       clic_int_ack_id,
    output logic [INTNUM-1:0]     clic_int_vld
);

    // Trigger-mode encodings, two bits per line
    localparam logic [1:0] c_MODE_LVL_HIGH = 2'b00;
    localparam logic [1:0] c_MODE_LVL_LOW  = 2'b01;
    localparam logic [1:0] c_MODE_RISE     = 2'b10;
    localparam logic [1:0] c_MODE_FALL     = 2'b11;

    // Synchronizer chain; stage 0 samples the asynchronous pins
    logic [INTNUM-1:0]   r_sync [SYNC_STAGES];
    // Synchronized level of the previous cycle, for edge detection
    logic [INTNUM-1:0]   r_hist;
    // Trigger mode seen last cycle; a difference from cfg marks a mode change
    logic [2*INTNUM-1:0] r_mode;
    // Next value of the output register, one bit per line
    logic [INTNUM-1:0]   w_vld_nxt;
    // Synchronized pin level (last synchronizer stage)
    logic [INTNUM-1:0]   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    // Synchronizer chain, edge history and mode snapshot
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
            r_hist <= '0;
            r_mode <= '0;
        end else begin
            r_sync[0] <= pad_int_raw;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            r_hist <= w_s;
            r_mode <= cfg_trig_mode;
        end
    end

    // Per-line trigger decode
    for (genvar i = 0; i < INTNUM; i++) begin : g_line
        logic [1:0] w_mode;
        logic       w_mode_chg;
        logic       w_clr;
        logic       w_rise;
        logic       w_fall;
        logic       w_keep;
        logic       w_nxt;

        assign w_mode     = r_mode[2*i +: 2];
        assign w_mode_chg = (cfg_trig_mode[2*i +: 2] != w_mode);
        // Ids that do not name a real line never match any i
        assign w_clr      = clic_int_ack_vld && (32'(clic_int_ack_id) == i);
        assign w_rise     = w_s[i] & ~r_hist[i];
        assign w_fall     = ~w_s[i] & r_hist[i];
        // Pending bit survives unless acknowledged; a fresh edge below wins
        assign w_keep     = clic_int_vld[i] & ~w_clr;

        // Next output for this line; a mode change flushes it and masks edges
        always_comb begin
            w_nxt = 1'b0;
            if (!w_mode_chg) begin
                case (w_mode)
                    c_MODE_LVL_HIGH: w_nxt = w_s[i];
                    c_MODE_LVL_LOW:  w_nxt = ~w_s[i];
                    c_MODE_RISE:     w_nxt = w_keep | w_rise;
                    c_MODE_FALL:     w_nxt = w_keep | w_fall;
                    default:         w_nxt = 1'b0;
                endcase
            end
        end

        assign w_vld_nxt[i] = w_nxt;
    end

    // Registered request vector toward the CLIC
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            clic_int_vld <= '0;
        end else begin
            clic_int_vld <= w_vld_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clic_int_src_cond.sv
`default_nettype none
// ============================================================================
// Module   : tb_clic_int_src_cond
// Brief    : Directed self-checking bench for clic_int_src_cond: reset,
//            level modes, rising/falling edge pending, ack collision,
//            mode change and reset while edges are pending.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clic_int_src_cond;

    localparam int INTNUM      = 64;
    localparam int SYNC_STAGES = 2;
    localparam int ID_W        = 6;

    logic                forever_cpuclk;
    logic                cpurst_b;
    logic [INTNUM-1:0]   pad_int_raw;
    logic [2*INTNUM-1:0] cfg_trig_mode;
    logic                clic_int_ack_vld;
    logic [ID_W-1:0]     clic_int_ack_id;
    logic [INTNUM-1:0]   clic_int_vld;

    int n_cmp;
    int n_err;

    clic_int_src_cond #(
        .INTNUM      (INTNUM),
        .SYNC_STAGES (SYNC_STAGES),
        .ID_W        (ID_W)
    ) u_dut (
        .forever_cpuclk   (forever_cpuclk),
        .cpurst_b         (cpurst_b),
        .pad_int_raw      (pad_int_raw),
        .cfg_trig_mode    (cfg_trig_mode),
        .clic_int_ack_vld (clic_int_ack_vld),
        .clic_int_ack_id  (clic_int_ack_id),
        .clic_int_vld     (clic_int_vld)
    );

    // 10 ns clock
    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    // Advance one clock; inputs driven and outputs sampled 1 ns after the edge
    task automatic tick();
        @(posedge forever_cpuclk);
        #1;
    endtask

    task automatic do_reset();
        cpurst_b         = 1'b0;
        pad_int_raw      = '0;
        clic_int_ack_vld = 1'b0;
        clic_int_ack_id  = '0;
        tick();
        cpurst_b = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_reset();
        logic [INTNUM-1:0] exp_v;
        cpurst_b    = 1'b0;
        pad_int_raw = '1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (clic_int_vld !== '0) begin
                n_err++;
                $display("FAIL reset_hold[%0d] got %h expected %h", c, clic_int_vld, 64'h0);
            end
        end
        cpurst_b = 1'b1;
        tick();
        n_cmp++;
        if (clic_int_vld !== '0) begin
            n_err++;
            $display("FAIL rel_edge0 got %h expected %h", clic_int_vld, 64'h0);
        end
        tick();
        exp_v = 64'h0000_0000_0000_0020;
        n_cmp++;
        if (clic_int_vld !== exp_v) begin
            n_err++;
            $display("FAIL rel_edge1 got %h expected %h", clic_int_vld, exp_v);
        end
        tick();
        exp_v = 64'hFFFF_FFFF_FFFF_FFDE;
        n_cmp++;
        if (clic_int_vld !== exp_v) begin
            n_err++;
            $display("FAIL rel_edge2 got %h expected %h", clic_int_vld, exp_v);
        end
    endtask

    task automatic test_level();
        do_reset();
        pad_int_raw[5] = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (clic_int_vld[5] !== 1'b0) begin
            n_err++;
            $display("FAIL lvl_low_raw_hi got %b expected 0", clic_int_vld[5]);
        end
        pad_int_raw[5] = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (clic_int_vld[5] !== 1'b0) begin
            n_err++;
            $display("FAIL lvl_low_early got %b expected 0", clic_int_vld[5]);
        end
        tick();
        n_cmp++;
        if (clic_int_vld[5] !== 1'b1) begin
            n_err++;
            $display("FAIL lvl_low_set got %b expected 1", clic_int_vld[5]);
        end
        clic_int_ack_vld = 1'b1;
        clic_int_ack_id  = 6'd5;
        tick();
        clic_int_ack_vld = 1'b0;
        n_cmp++;
        if (clic_int_vld[5] !== 1'b1) begin
            n_err++;
            $display("FAIL lvl_ack_ignored got %b expected 1", clic_int_vld[5]);
        end
        pad_int_raw[5] = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (clic_int_vld[5] !== 1'b1) begin
            n_err++;
            $display("FAIL lvl_low_hold got %b expected 1", clic_int_vld[5]);
        end
        tick();
        n_cmp++;
        if (clic_int_vld[5] !== 1'b0) begin
            n_err++;
            $display("FAIL lvl_low_clr got %b expected 0", clic_int_vld[5]);
        end
    endtask

    task automatic test_rise();
        do_reset();
        pad_int_raw[17] = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (clic_int_vld[17] !== 1'b0) begin
            n_err++;
            $display("FAIL rise_early got %b expected 0", clic_int_vld[17]);
        end
        tick();
        n_cmp++;
        if (clic_int_vld[17] !== 1'b1) begin
            n_err++;
            $display("FAIL rise_set got %b expected 1", clic_int_vld[17]);
        end
        tick();
        pad_int_raw[17] = 1'b0;
        repeat (5) tick();
        n_cmp++;
        if (clic_int_vld[17] !== 1'b1) begin
            n_err++;
            $display("FAIL rise_sticky got %b expected 1", clic_int_vld[17]);
        end
        clic_int_ack_vld = 1'b1;
        clic_int_ack_id  = 6'd18;
        tick();
        n_cmp++;
        if ({clic_int_vld[18], clic_int_vld[17]} !== 2'b01) begin
            n_err++;
            $display("FAIL ack_other_id got %b expected 01", {clic_int_vld[18], clic_int_vld[17]});
        end
        clic_int_ack_id = 6'd17;
        tick();
        clic_int_ack_vld = 1'b0;
        n_cmp++;
        if (clic_int_vld[17] !== 1'b0) begin
            n_err++;
            $display("FAIL ack_clear got %b expected 0", clic_int_vld[17]);
        end
        tick();
        n_cmp++;
        if (clic_int_vld[17] !== 1'b0) begin
            n_err++;
            $display("FAIL ack_stay_clr got %b expected 0", clic_int_vld[17]);
        end
    endtask

    task automatic test_collision();
        do_reset();
        pad_int_raw[0] = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (clic_int_vld[0] !== 1'b0) begin
            n_err++;
            $display("FAIL fall_ignores_rise got %b expected 0", clic_int_vld[0]);
        end
        pad_int_raw[0] = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (clic_int_vld[0] !== 1'b1) begin
            n_err++;
            $display("FAIL fall_set got %b expected 1", clic_int_vld[0]);
        end
        pad_int_raw[0] = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (clic_int_vld[0] !== 1'b1) begin
            n_err++;
            $display("FAIL fall_pending_hold got %b expected 1", clic_int_vld[0]);
        end
        pad_int_raw[0] = 1'b0;
        repeat (2) tick();
        clic_int_ack_vld = 1'b1;
        clic_int_ack_id  = 6'd0;
        tick();
        n_cmp++;
        if (clic_int_vld[0] !== 1'b1) begin
            n_err++;
            $display("FAIL collision_set_wins got %b expected 1", clic_int_vld[0]);
        end
        tick();
        clic_int_ack_vld = 1'b0;
        n_cmp++;
        if (clic_int_vld[0] !== 1'b0) begin
            n_err++;
            $display("FAIL second_ack_clr got %b expected 0", clic_int_vld[0]);
        end
    endtask

    task automatic test_mode_change();
        do_reset();
        pad_int_raw[40] = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (clic_int_vld[40] !== 1'b1) begin
            n_err++;
            $display("FAIL mode_rise_set got %b expected 1", clic_int_vld[40]);
        end
        tick();
        cfg_trig_mode[81:80] = 2'b00;
        tick();
        n_cmp++;
        if (clic_int_vld[40] !== 1'b0) begin
            n_err++;
            $display("FAIL mode_to_lvl_flush got %b expected 0", clic_int_vld[40]);
        end
        tick();
        n_cmp++;
        if (clic_int_vld[40] !== 1'b1) begin
            n_err++;
            $display("FAIL mode_lvl_applies got %b expected 1", clic_int_vld[40]);
        end
        cfg_trig_mode[81:80] = 2'b10;
        tick();
        n_cmp++;
        if (clic_int_vld[40] !== 1'b0) begin
            n_err++;
            $display("FAIL mode_to_rise_flush got %b expected 0", clic_int_vld[40]);
        end
        repeat (3) tick();
        n_cmp++;
        if (clic_int_vld[40] !== 1'b0) begin
            n_err++;
            $display("FAIL mode_rise_no_edge got %b expected 0", clic_int_vld[40]);
        end
    endtask

    task automatic test_reset_mid_pending();
        do_reset();
        pad_int_raw[3]  = 1'b1;
        pad_int_raw[63] = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({clic_int_vld[63], clic_int_vld[3]} !== 2'b11) begin
            n_err++;
            $display("FAIL pend_set got %b expected 11", {clic_int_vld[63], clic_int_vld[3]});
        end
        pad_int_raw[3] = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({clic_int_vld[63], clic_int_vld[3]} !== 2'b11) begin
            n_err++;
            $display("FAIL pend_hold got %b expected 11", {clic_int_vld[63], clic_int_vld[3]});
        end
        cpurst_b = 1'b0;
        tick();
        cpurst_b = 1'b1;
        n_cmp++;
        if (clic_int_vld !== '0) begin
            n_err++;
            $display("FAIL mid_reset_clear got %h expected %h", clic_int_vld, 64'h0);
        end
        repeat (2) tick();
        n_cmp++;
        if ({clic_int_vld[63], clic_int_vld[3]} !== 2'b00) begin
            n_err++;
            $display("FAIL post_reset_early got %b expected 00", {clic_int_vld[63], clic_int_vld[3]});
        end
        tick();
        n_cmp++;
        if ({clic_int_vld[63], clic_int_vld[3]} !== 2'b10) begin
            n_err++;
            $display("FAIL post_reset_rise got %b expected 10", {clic_int_vld[63], clic_int_vld[3]});
        end
    endtask

    initial begin
        n_cmp            = 0;
        n_err            = 0;
        cpurst_b         = 1'b0;
        pad_int_raw      = '0;
        clic_int_ack_vld = 1'b0;
        clic_int_ack_id  = '0;
        cfg_trig_mode    = '0;
        cfg_trig_mode[1:0]     = 2'b11;  // line 0  falling
        cfg_trig_mode[7:6]     = 2'b10;  // line 3  rising
        cfg_trig_mode[11:10]   = 2'b01;  // line 5  level-low
        cfg_trig_mode[35:34]   = 2'b10;  // line 17 rising
        cfg_trig_mode[81:80]   = 2'b10;  // line 40 rising
        cfg_trig_mode[127:126] = 2'b10;  // line 63 rising

        test_reset();
        test_level();
        test_rise();
        test_collision();
        test_mode_change();
        test_reset_mid_pending();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
